mux4_rr_arbiter: RTL
====================

# mux4_rr_arbiter

Round-robin arbiter and sequencer for the 4:1 select mux. Four sources each request ownership of the shared mux output. The block grants exactly one owner at a time, drives the mux select from that grant, and registers the selected data. It sits between the four requesting sources and the single downstream consumer of the muxed stream.

## Interface
- DW, 1: data width per source.
- MAX_HOLD, 15: maximum tenure in cycles. Used only when the timeout feature is compiled in; legal range 1..255.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per source; req[i] is held high for the whole tenure.
- din  input  4*DW  source data; source i is on din[i*DW +: DW].
- gnt  output  4  one-hot grant; all zeros when idle.
- sel  output  2  encoded owner index; drives the mux select.
- valid  output  1  high while any grant is active.
- y  output  DW  registered muxed data.
- timeout  output  1  one-cycle pulse on a forced revoke; constant 0 when the feature is compiled out.

## Operation
- State machine has two states: IDLE and GRANT. Priority pointer ptr is 2 bits.
- Arbitration scans req starting at index ptr and moving upward, wrapping 3→0. The first set bit wins.
- IDLE:
  - If req is nonzero, go to GRANT with the winner as owner.
  - Otherwise stay in IDLE with gnt=0 and valid=0.
- GRANT while req[owner]=1: hold the owner. gnt, sel and valid do not change.
- GRANT when req[owner]=0 (release):
  - Set ptr to owner+1 mod 4 (3 wraps to 0).
  - Re-arbitrate the current req using the new pointer in the same cycle.
  - If there is a winner, hand over directly with no idle bubble.
  - If there is no winner, go to IDLE.
- Invariants:
  - A source that was just released gets lowest priority on the next arbitration.
  - gnt is always one-hot or zero.
  - gnt[sel] equals valid.
- y is updated every cycle:
  - Load din[sel] when the next state is GRANT.
  - Load 0 when the next state is IDLE.
- req bits of non-owners are ignored until the next arbitration.

## Timing
- Reset values: state IDLE, ptr=0, gnt=4'b0000, sel=2'b00, valid=0, y=0, timeout=0.
- Reset asserted mid-tenure clears all outputs at the next edge, whatever req is doing.
- Grant latency: req sampled at edge n gives gnt/sel/valid at edge n+1.
- Data latency:
  - y shows din[owner] sampled at the same edge that first asserts gnt.
  - After that, y lags din by one cycle.
- Release: req[owner] low at edge m gives the new owner, or idle, at edge m+1.
- Fairness: a continuously requesting source waits at most 3 full tenures.
- Simultaneous requests in IDLE: the lowest index at or above ptr wins. After reset, source 0 has highest priority.
- Release and new requests in the same cycle: the new requests take part in that re-arbitration.

## Configuration
- MUX4_ARB_TIMEOUT_EN defined:
  - An 8-bit tenure counter clears on every new grant and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD and another source is requesting, the owner is revoked exactly as if it had released. timeout pulses high for that one cycle.
  - If no other source is requesting, the tenure continues and the counter saturates at MAX_HOLD.
  - A revoked source that keeps req high is treated as a normal requester and waits its turn.
- MUX4_ARB_TIMEOUT_EN not defined: no counter, timeout tied to 0, tenure unbounded.

## Test plan
- Reset then single request:
  - Stimulus: rst for 2 cycles, then req=4'b0100, din source 2 = 1.
  - Required: next edge gnt=0100, sel=10, valid=1; y=1 at the same edge.
- Simultaneous requests after reset:
  - Stimulus: req=4'b1010.
  - Required: gnt=0010.
  - Then drop req[1]. Required: gnt=1000 one cycle later with valid never low.
- Round-robin wrap:
  - Stimulus: req=4'b1111, each owner releases for 1 cycle after 3 cycles of tenure.
  - Required: grant order 0,1,2,3,0.
- Release to idle:
  - Stimulus: sole owner 3 drops req.
  - Required: next edge gnt=0000, valid=0, y=0, and ptr points at 0 (the next req=4'b1001 grants 0).
- Reset mid-tenure:
  - Stimulus: owner 1 active, assert rst for 1 cycle with req held high.
  - Required: all outputs at reset values at that edge. After rst falls, gnt=0010 is regranted one cycle later.
- Timeout (MUX4_ARB_TIMEOUT_EN, MAX_HOLD=4):
  - Stimulus: owner 0 holds req with req[2] also high.
  - Required: after 4 GRANT cycles, timeout=1 for one cycle and gnt=0100.
  - With req[2] low instead, owner 0 keeps the grant indefinitely.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// Request/data bundle between the four sources and the round-robin mux arbiter.
// The master side drives req/din; the slave side (the arbiter) drives grant, select and muxed data.
interface mux4_rr_arbiter_if #(
    parameter int DW = 1
);
    logic [3:0]      req;
    logic [4*DW-1:0] din;
    logic [3:0]      gnt;
    logic [1:0]      sel;
    logic            valid;
    logic [DW-1:0]   y;
    logic            timeout;

    modport master (
        output req, din,
        input  gnt, sel, valid, y, timeout
    );

    modport slave (
        input  req, din,
        output gnt, sel, valid, y, timeout
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a 4:1 mux: one owner at a time, encoded select, registered muxed data.
// Optional tenure limit is compiled in with the MUX4_ARB_TIMEOUT_EN macro.
module mux4_rr_arbiter #(
    parameter int DW       = 1,
    parameter int MAX_HOLD = 15
) (
    input  logic               clk,
    input  logic               rst,
    mux4_rr_arbiter_if.slave   bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      sel_q, sel_d;
    logic [DW-1:0]   y_q, y_d;
    logic [2:0]      pick;
    logic            others;
    logic            expire;
    logic            revoke;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux4_rr_arbiter: MAX_HOLD must be within 1..255");
    end

    // Returns {found, index} of the first set request at or above start, wrapping 3 -> 0.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign others = |(bus.req & ~(4'b0001 << sel_q));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        pick    = 3'b000;
        revoke  = 1'b0;
        case (state_q)
            IDLE: begin
                pick = rr_pick(bus.req, ptr_q);
                if (pick[2]) begin
                    state_d = GRANT;
                    sel_d   = pick[1:0];
                end
            end
            GRANT: begin
                revoke = bus.req[sel_q] & expire & others;
                if (!bus.req[sel_q] || revoke) begin
                    // Released owner drops to lowest priority; hand over in the same cycle.
                    ptr_d = sel_q + 2'd1;
                    pick  = rr_pick(bus.req, sel_q + 2'd1);
                    if (pick[2]) begin
                        sel_d = pick[1:0];
                    end else begin
                        state_d = IDLE;
                        sel_d   = 2'b00;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = 2'b00;
            end
        endcase
        y_d = (state_d == GRANT) ? bus.din[int'(sel_d)*DW +: DW] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'b00;
            sel_q   <= 2'b00;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            y_q     <= y_d;
        end
    end

`ifdef MUX4_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD = 8'(MAX_HOLD);

    logic [7:0] cnt_q, cnt_d;
    logic       new_grant;
    logic       timeout_q;

    // cnt_q + 1 is the number of GRANT cycles the current owner has held once this edge is taken.
    assign expire    = ({1'b0, cnt_q} + 9'd1) >= {1'b0, HOLD};
    assign new_grant = (state_d == GRANT) && ((state_q == IDLE) || (sel_d != sel_q));

    always_comb begin
        cnt_d = 8'd0;
        if (new_grant) begin
            cnt_d = 8'd0;
        end else if (state_q == GRANT) begin
            cnt_d = (cnt_q >= HOLD) ? HOLD : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= revoke;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign expire      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.valid = (state_q == GRANT);
    assign bus.gnt   = (state_q == GRANT) ? (4'b0001 << sel_q) : 4'b0000;
    assign bus.sel   = sel_q;
    assign bus.y     = y_q;

endmodule
